l1_fill_responder: RTL and testbench

L1_FILL_RESPONDER -- requirements
Module: l1_fill_responder

---
 rtl/l1_fill_responder_if.sv | 21 ++
 rtl/l1_fill_responder.sv | 204 ++++++++++++++++++++
 tb/tb_l1_fill_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_fill_responder_if.sv
// Cache-side request/response bus of the L1 fill responder.
// The cache drives the request (master); the responder answers (slave).
interface l1_fill_responder_if;
  logic        I_req;
  logic [31:0] I_addr;
  logic        I_write;
  logic [31:0] I_in;
  logic [2:0]  I_type;
  logic [31:0] I_out;
  logic        I_wait;

  modport master (
    output I_req, I_addr, I_write, I_in, I_type,
    input  I_out, I_wait
  );

  modport slave (
    input  I_req, I_addr, I_write, I_in, I_type,
    output I_out, I_wait
  );
endinterface

// File: rtl/l1_fill_responder.sv
// L1 fill responder: turns cache requests into single-port SRAM accesses
// with a programmable wait latency, shortened for in-line sequential reads.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for I_req; I_wait mirrors I_req
// S_WAIT   | latency countdown before the SRAM access
// S_ACCESS | SRAM read strobe active, data returns next cycle
// S_WRITE  | SRAM write strobe active with lane-aligned data
// S_RESP   | one-cycle response, I_wait=0
module l1_fill_responder #(
  parameter int FIRST_LAT = 2,
  parameter int NEXT_LAT  = 0,
  parameter int AW        = 14
) (
  input  logic               clk,
  input  logic               rst,
  l1_fill_responder_if.slave bus,
  output logic               mem_cs,
  output logic               mem_oe,
  output logic [3:0]         mem_web,
  output logic [AW-1:0]      mem_addr,
  output logic [31:0]        mem_di,
  input  logic [31:0]        mem_do
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    type_q, type_d;
  logic          seq_q, seq_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_oe_q, mem_oe_d;
  logic [3:0]    mem_web_q, mem_web_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_di_q, mem_di_d;

  logic          seq_hit;
  logic [3:0]    lat;
  logic [35:0]   lanes_in, lanes_lat;

  // Byte enables (active low) and shifted data for a write: {web, di}.
  function automatic logic [35:0] wr_lanes(input logic [1:0] off, input logic [2:0] ty,
                                           input logic [31:0] d);
    logic [3:0]  web;
    logic [31:0] di;
    case (ty)
      3'b000, 3'b100: begin
        web = ~(4'b0001 << off);
        di  = {24'b0, d[7:0]} << {off, 3'b000};
      end
      3'b001, 3'b101: begin
        if (off[1]) begin
          web = 4'b0011;
          di  = {d[15:0], 16'b0};
        end else begin
          web = 4'b1100;
          di  = {16'b0, d[15:0]};
        end
      end
      default: begin
        web = 4'b0000;
        di  = d;
      end
    endcase
    return {web, di};
  endfunction

  // Extracts and extends a byte/half from the SRAM word; unlisted types read as word.
  function automatic logic [31:0] rd_fmt(input logic [31:0] d, input logic [1:0] off,
                                         input logic [2:0] ty);
    logic [31:0] sh;
    logic [15:0] h;
    sh = d >> {off, 3'b000};
    h  = off[1] ? d[31:16] : d[15:0];
    case (ty)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

  // In-line sequential read: previous read responded last cycle, next word of the same line.
  always_comb begin
    seq_hit = seq_q && !bus.I_write && (bus.I_addr == addr_q + 32'd4) &&
              (bus.I_addr[31:4] == addr_q[31:4]);
    lat       = seq_hit ? 4'(NEXT_LAT) : 4'(FIRST_LAT);
    lanes_in  = wr_lanes(bus.I_addr[1:0], bus.I_type, bus.I_in);
    lanes_lat = wr_lanes(addr_q[1:0], type_q, wdata_q);
  end

  // Next-state and next-output logic; SRAM strobes are registered so they
  // are active exactly during S_ACCESS / S_WRITE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    type_d     = type_q;
    seq_d      = 1'b0;
    mem_cs_d   = 1'b0;
    mem_oe_d   = 1'b0;
    mem_web_d  = 4'hF;
    mem_addr_d = mem_addr_q;
    mem_di_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.I_req) begin
          addr_d     = bus.I_addr;
          write_d    = bus.I_write;
          wdata_d    = bus.I_in;
          type_d     = bus.I_type;
          cnt_d      = lat;
          mem_addr_d = bus.I_addr[AW+1:2];
          if (lat != 4'd0) begin
            state_d = S_WAIT;
          end else if (bus.I_write) begin
            state_d   = S_WRITE;
            mem_cs_d  = 1'b1;
            mem_web_d = lanes_in[35:32];
            mem_di_d  = lanes_in[31:0];
          end else begin
            state_d  = S_ACCESS;
            mem_cs_d = 1'b1;
            mem_oe_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (write_q) begin
            state_d   = S_WRITE;
            mem_cs_d  = 1'b1;
            mem_web_d = lanes_lat[35:32];
            mem_di_d  = lanes_lat[31:0];
          end else begin
            state_d  = S_ACCESS;
            mem_cs_d = 1'b1;
            mem_oe_d = 1'b1;
          end
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_WRITE:  state_d = S_RESP;
      S_RESP: begin
        state_d = S_IDLE;
        seq_d   = !write_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single state/output register bank with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      type_q     <= '0;
      seq_q      <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_oe_q   <= 1'b0;
      mem_web_q  <= 4'hF;
      mem_addr_q <= '0;
      mem_di_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      type_q     <= type_d;
      seq_q      <= seq_d;
      mem_cs_q   <= mem_cs_d;
      mem_oe_q   <= mem_oe_d;
      mem_web_q  <= mem_web_d;
      mem_addr_q <= mem_addr_d;
      mem_di_q   <= mem_di_d;
    end
  end

  // Response side is combinational: SRAM data is only valid during S_RESP.
  always_comb begin
    bus.I_wait = (state_q == S_IDLE) ? bus.I_req : (state_q != S_RESP);
    bus.I_out  = (state_q == S_RESP && !write_q) ? rd_fmt(mem_do, addr_q[1:0], type_q) : 32'd0;
  end

  assign mem_cs   = mem_cs_q;
  assign mem_oe   = mem_oe_q;
  assign mem_web  = mem_web_q;
  assign mem_addr = mem_addr_q;
  assign mem_di   = mem_di_q;

endmodule

// File: tb/tb_l1_fill_responder.sv
// Directed bench for l1_fill_responder with a behavioural SRAM model.
module tb_l1_fill_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_cs, mem_oe;
  logic [3:0]  mem_web;
  logic [13:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;

  int tests = 0;
  int fails = 0;

  l1_fill_responder_if bus ();

  l1_fill_responder dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, byte-masked write, plus a preload port.
  logic [31:0] mem [0:255];
  logic        mem_clr, pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  logic [3:0]  wr_web;
  logic [31:0] wr_di;
  logic [13:0] wr_addr;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_cs && !mem_oe) begin
      for (int i = 0; i < 4; i++)
        if (!mem_web[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_di[8*i +: 8];
    end
    if (mem_cs && !mem_oe) begin
      wr_web   <= mem_web;
      wr_di    <= mem_di;
      wr_addr  <= mem_addr;
      wr_count <= wr_count + 1;
    end
    mem_do <= (mem_cs && mem_oe) ? mem[mem_addr[7:0]] : 32'hDEADBEEF;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Issues one request starting this cycle; returns cycles until I_wait=0 and I_out then.
  task automatic run_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [2:0] ty, input bit drop,
                         output int lat, output logic [31:0] dout);
    bus.I_req   = 1'b1;
    bus.I_addr  = a;
    bus.I_write = w;
    bus.I_in    = d;
    bus.I_type  = ty;
    lat  = -1;
    dout = 32'd0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (bus.I_wait === 1'b0) begin
        lat  = n;
        dout = bus.I_out;
        break;
      end
      @(posedge clk);
      #1;
      if (drop) bus.I_req = 1'b0;
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL timeout addr=%h: no response within 24 cycles", a);
    end
    @(posedge clk);
    #1;
    bus.I_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (mem_cs !== 1'b0 || mem_oe !== 1'b0) begin
      fails++; $display("FAIL reset_strobe got cs=%b oe=%b exp 0 0", mem_cs, mem_oe);
    end
    tests++;
    if (mem_web !== 4'hF || mem_di !== 32'd0 || mem_addr !== 14'd0) begin
      fails++; $display("FAIL reset_sram got web=%h di=%h addr=%h exp F 0 0", mem_web, mem_di, mem_addr);
    end
    tests++;
    if (bus.I_out !== 32'd0 || bus.I_wait !== 1'b0) begin
      fails++; $display("FAIL reset_bus got out=%h wait=%b exp 0 0", bus.I_out, bus.I_wait);
    end
    bus.I_req = 1'b1;
    #1;
    tests++;
    if (bus.I_wait !== 1'b1) begin
      fails++; $display("FAIL reset_wait_follow got %b exp 1", bus.I_wait);
    end
    bus.I_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_clr = 1'b0;
    idle(1);
  endtask

  task automatic test_word_read();
    int lat; logic [31:0] dout;
    preload(8'h10, 32'h12345678);
    run_req(32'h40, 1'b0, 32'd0, 3'b010, 1'b0, lat, dout);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL word_read_lat got %0d exp 4", lat); end
    tests++;
    if (dout !== 32'h12345678) begin fails++; $display("FAIL word_read_data got %h exp 12345678", dout); end
    @(negedge clk);
    tests++;
    if (bus.I_out !== 32'd0 || bus.I_wait !== 1'b0) begin
      fails++; $display("FAIL idle_out got out=%h wait=%b exp 0 0", bus.I_out, bus.I_wait);
    end
    idle(1);
  endtask

  task automatic test_line_fill();
    int lat; logic [31:0] dout;
    logic [31:0] exp_d [4];
    int          exp_l [4];
    exp_d = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    exp_l = '{4, 2, 2, 2};
    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), exp_d[i]);
    preload(8'h44, 32'h0BADF00D);
    for (int i = 0; i < 4; i++) begin
      run_req(32'h100 + 32'(4*i), 1'b0, 32'd0, 3'b010, (i == 3), lat, dout);
      tests++;
      if (lat !== exp_l[i]) begin fails++; $display("FAIL fill_lat[%0d] got %0d exp %0d", i, lat, exp_l[i]); end
      tests++;
      if (dout !== exp_d[i]) begin fails++; $display("FAIL fill_data[%0d] got %h exp %h", i, dout, exp_d[i]); end
    end
    // next line right after the last word: full latency again
    run_req(32'h110, 1'b0, 32'd0, 3'b010, 1'b0, lat, dout);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL new_line_lat got %0d exp 4", lat); end
    tests++;
    if (dout !== 32'h0BADF00D) begin fails++; $display("FAIL new_line_data got %h exp 0badf00d", dout); end
    idle(1);
  endtask

  task automatic test_subword_read();
    int lat; logic [31:0] dout;
    logic [31:0] a   [4];
    logic [2:0]  ty  [4];
    logic [31:0] exp [4];
    a   = '{32'h103, 32'h103, 32'h102, 32'h100};
    ty  = '{3'b000, 3'b100, 3'b001, 3'b101};
    exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000FF7F};
    preload(8'h40, 32'h80FFFF7F);
    for (int i = 0; i < 4; i++) begin
      run_req(a[i], 1'b0, 32'd0, ty[i], 1'b0, lat, dout);
      tests++;
      if (dout !== exp[i]) begin fails++; $display("FAIL subword[%0d] got %h exp %h", i, dout, exp[i]); end
      idle(1);
    end
  endtask

  task automatic test_write();
    int lat; logic [31:0] dout;
    int wc;
    preload(8'h80, 32'h11223344);
    wc = wr_count;
    run_req(32'h202, 1'b1, 32'h0000BEEF, 3'b001, 1'b0, lat, dout);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL half_wr_lat got %0d exp 4", lat); end
    tests++;
    if (wr_web !== 4'b0011 || wr_di !== 32'hBEEF0000 || wr_addr !== 14'h80) begin
      fails++; $display("FAIL half_wr_sram got web=%b di=%h addr=%h exp 0011 beef0000 80", wr_web, wr_di, wr_addr);
    end
    tests++;
    if (dout !== 32'd0 || wr_count !== wc + 1) begin
      fails++; $display("FAIL half_wr_resp got out=%h writes=%0d exp 0 %0d", dout, wr_count - wc, 1);
    end
    tests++;
    if (mem[8'h80] !== 32'hBEEF3344) begin fails++; $display("FAIL half_wr_mem got %h exp beef3344", mem[8'h80]); end
    idle(1);
    run_req(32'h205, 1'b1, 32'h000000A5, 3'b000, 1'b0, lat, dout);
    tests++;
    if (wr_web !== 4'b1101 || wr_di !== 32'h0000A500 || wr_addr !== 14'h81) begin
      fails++; $display("FAIL byte_wr_sram got web=%b di=%h addr=%h exp 1101 0000a500 81", wr_web, wr_di, wr_addr);
    end
    idle(1);
    run_req(32'h200, 1'b1, 32'h00001234, 3'b101, 1'b0, lat, dout);
    tests++;
    if (wr_web !== 4'b1100 || wr_di !== 32'h00001234) begin
      fails++; $display("FAIL half_lo_wr got web=%b di=%h exp 1100 00001234", wr_web, wr_di);
    end
    tests++;
    if (mem[8'h80] !== 32'hBEEF1234) begin fails++; $display("FAIL half_lo_mem got %h exp beef1234", mem[8'h80]); end
    idle(1);
    // write right after a read to the next address is never sequential
    preload(8'hC0, 32'h5A5A5A5A);
    run_req(32'h300, 1'b0, 32'd0, 3'b010, 1'b0, lat, dout);
    run_req(32'h304, 1'b1, 32'hCAFEF00D, 3'b010, 1'b0, lat, dout);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL word_wr_after_rd_lat got %0d exp 4", lat); end
    tests++;
    if (wr_web !== 4'b0000 || mem[8'hC1] !== 32'hCAFEF00D) begin
      fails++; $display("FAIL word_wr got web=%b mem=%h exp 0000 cafef00d", wr_web, mem[8'hC1]);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] dout;
    int wc;
    wc = wr_count;
    bus.I_req   = 1'b1;
    bus.I_addr  = 32'h20C;
    bus.I_write = 1'b1;
    bus.I_in    = 32'hFFFFFFFF;
    bus.I_type  = 3'b010;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (mem_cs !== 1'b0 || bus.I_wait !== 1'b1) begin
      fails++; $display("FAIL mid_reset got cs=%b wait=%b exp 0 1", mem_cs, bus.I_wait);
    end
    bus.I_req = 1'b0;
    #1;
    tests++;
    if (bus.I_wait !== 1'b0) begin fails++; $display("FAIL mid_reset_wait got %b exp 0", bus.I_wait); end
    idle(2);
    rst = 1'b0;
    idle(4);
    tests++;
    if (wr_count !== wc || mem[8'h83] !== 32'd0) begin
      fails++; $display("FAIL mid_reset_nowrite got writes=%0d mem=%h exp 0 0", wr_count - wc, mem[8'h83]);
    end
    run_req(32'h40, 1'b0, 32'd0, 3'b010, 1'b0, lat, dout);
    tests++;
    if (lat !== 4 || dout !== 32'h12345678) begin
      fails++; $display("FAIL after_reset_read got lat=%0d data=%h exp 4 12345678", lat, dout);
    end
  endtask

  initial begin
    rst         = 1'b1;
    mem_clr     = 1'b1;
    pl_en       = 1'b0;
    pl_addr     = 8'd0;
    pl_data     = 32'd0;
    bus.I_req   = 1'b0;
    bus.I_addr  = 32'd0;
    bus.I_write = 1'b0;
    bus.I_in    = 32'd0;
    bus.I_type  = 3'b010;
    idle(2);
    test_reset();
    test_word_read();
    test_line_fill();
    test_subword_read();
    test_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
